// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU definitions: widths, SPECIAL-opcode function codes and FSM states.
// Imported by the sequencer, its iterative core and the controller decode.
package mdu_sequencer_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] F_MFHI     = 6'b010000;
  localparam logic [5:0] F_MTHI     = 6'b010001;
  localparam logic [5:0] F_MFLO     = 6'b010010;
  localparam logic [5:0] F_MTLO     = 6'b010011;
  localparam logic [5:0] F_MULT     = 6'b011000;
  localparam logic [5:0] F_MULTU    = 6'b011001;
  localparam logic [5:0] F_DIV      = 6'b011010;
  localparam logic [5:0] F_DIVU     = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  function automatic logic is_mdu_func(input logic [5:0] func);
    logic hit;
    case (func)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: hit = 1'b1;
      default:                        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle multiply/divide datapath on unsigned magnitudes.
// A single 2*XLEN accumulator holds {hi_partial, multiplier} or {remainder, quotient}.
module mdu_iter_core
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic              step,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod64,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);

  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   b_r;
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [XLEN:0]     sum_s;
  logic [XLEN:0]     shl_s;
  logic [XLEN:0]     diff_s;

  // Next accumulator: shift-add right for multiply, restoring shift-subtract left for divide
  always_comb begin
    sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
    shl_s  = acc_r[2*XLEN-1:XLEN-1];
    diff_s = shl_s - {1'b0, b_r};
    acc_nxt_s = acc_r;
    if (is_div) begin
      // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1
      if (!diff_s[XLEN]) begin
        acc_nxt_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = {shl_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = {sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Operand latch on start, one iteration per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {(2*XLEN){1'b0}};
      b_r   <= {XLEN{1'b0}};
    end else if (start) begin
      acc_r <= {{XLEN{1'b0}}, a};
      b_r   <= b;
    end else if (step) begin
      acc_r <= acc_nxt_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign prod64 = acc_r;
  assign quot   = acc_r[XLEN-1:0];
  assign rem    = acc_r[2*XLEN-1:XLEN];

endmodule

// File: rtl/mdu_sequencer.sv
// MDU sequencer: decodes MDU functs, runs the iterative core, applies sign fixup,
// owns HI/LO and stalls MDU instructions that arrive while an operation is in flight.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     IR,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] rd_data,
  output logic [3:0]      rd_byte_w_en,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return {XLEN{1'b0}} - v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return {(2*XLEN){1'b0}} - v;
  endfunction

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              quot_neg_r, rem_neg_r, op_div_r;
  logic [XLEN-1:0]   hi_r, lo_r;
  logic              start_s, step_s, core_div_s;
  logic [5:0]        func_s;
  logic              is_mdu_s, busy_s, accept_s;
  logic              is_mult_s, is_div_op_s, signed_op_s, sa_s, sb_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, quot_s, rem_s;
  logic [2*XLEN-1:0] prod_s;
  logic              ir_unused_s;

  assign func_s      = IR[5:0];
  assign ir_unused_s = ^IR[25:6];
  assign is_mdu_s    = in_valid && (IR[31:26] == OP_SPECIAL) && is_mdu_func(func_s);
  assign busy_s      = (state_r != ST_IDLE);
  assign accept_s    = is_mdu_s && !busy_s;
  assign is_mult_s   = (func_s == F_MULT) || (func_s == F_MULTU);
  assign is_div_op_s = (func_s == F_DIV)  || (func_s == F_DIVU);
  assign signed_op_s = (func_s == F_MULT) || (func_s == F_DIV);
  assign sa_s        = signed_op_s && rs_val[XLEN-1];
  assign sb_s        = signed_op_s && rt_val[XLEN-1];
  assign a_mag_s     = sa_s ? neg_x(rs_val) : rs_val;
  assign b_mag_s     = sb_s ? neg_x(rt_val) : rt_val;
  assign core_div_s  = (state_r == ST_DIV);

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_s),
    .is_div (core_div_s),
    .step   (step_s),
    .a      (a_mag_s),
    .b      (b_mag_s),
    .prod64 (prod_s),
    .quot   (quot_s),
    .rem    (rem_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and core control; the last iteration runs when cnt reaches XLEN-1
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mult_s) begin
          start_s     = 1'b1;
          state_nxt_s = ST_MUL;
        end else if (accept_s && is_div_op_s) begin
          start_s     = 1'b1;
          state_nxt_s = ST_DIV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        step_s = 1'b1;
        if (cnt_r == {CNT_W{1'b1}}) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Iteration counter and result sign flags captured at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      quot_neg_r <= 1'b0;
      rem_neg_r  <= 1'b0;
      op_div_r   <= 1'b0;
    end else if (start_s) begin
      cnt_r      <= {CNT_W{1'b0}};
      quot_neg_r <= sa_s ^ sb_s;
      rem_neg_r  <= sa_s;
      op_div_r   <= is_div_op_s;
    end else if (step_s) begin
      cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r      <= cnt_r;
    end
  end

  // HI/LO: signed fixup on FIX, direct writes from MTHI/MTLO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= {XLEN{1'b0}};
      lo_r <= {XLEN{1'b0}};
    end else if (state_r == ST_FIX) begin
      if (op_div_r) begin
        lo_r <= quot_neg_r ? neg_x(quot_s) : quot_s;
        hi_r <= rem_neg_r  ? neg_x(rem_s)  : rem_s;
      end else begin
        {hi_r, lo_r} <= quot_neg_r ? neg_2x(prod_s) : prod_s;
      end
    end else if (accept_s && (func_s == F_MTHI)) begin
      hi_r <= rs_val;
    end else if (accept_s && (func_s == F_MTLO)) begin
      lo_r <= rs_val;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // MFHI/MFLO read path; byte enables are active-low
  always_comb begin
    rd_data      = {XLEN{1'b0}};
    rd_byte_w_en = 4'b1111;
    if (accept_s && (func_s == F_MFHI)) begin
      rd_data      = hi_r;
      rd_byte_w_en = 4'b0000;
    end else if (accept_s && (func_s == F_MFLO)) begin
      rd_data      = lo_r;
      rd_byte_w_en = 4'b0000;
    end else begin
      rd_data      = {XLEN{1'b0}};
      rd_byte_w_en = 4'b1111;
    end
  end

  assign stall = is_mdu_s && busy_s;
  assign busy  = busy_s;
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus pushes expected HI/LO and MFHI/MFLO
// results; a monitor pops them when busy falls or a register read is presented.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] IR;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        busy;
  logic [31:0] rd_data;
  logic [3:0]  rd_byte_w_en;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_total = 0;
  int n_pass  = 0;

  logic [63:0] exp_hl_q[$];
  logic [31:0] exp_rd_q[$];

  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] ADDU = 6'b100001;

  mdu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .IR           (IR),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .stall        (stall),
    .busy         (busy),
    .rd_data      (rd_data),
    .rd_byte_w_en (rd_byte_w_en),
    .hi           (hi),
    .lo           (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'b000000, 20'h00000, f};
  endfunction

  // Present an instruction (called just after a rising edge) and hold it until consumed
  task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls);
    in_valid = 1'b1;
    IR       = rtype(f);
    rs_val   = rs;
    rt_val   = rt;
    stalls   = 0;
    @(negedge clk);
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) check("issue_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    IR       = 32'h0000_0000;
  endtask

  // Count rising edges until busy is seen low; bounded
  task automatic wait_idle(output int edges);
    edges = 0;
    @(negedge clk);
    while (busy && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare results whenever the DUT presents them
  initial begin
    logic prev_busy;
    logic [63:0] e_hl;
    logic [31:0] e_rd;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_byte_w_en == 4'b0000) begin
          if (exp_rd_q.size() == 0) begin
            check("rd_unexpected", 64'd1, 64'd0);
          end else begin
            e_rd = exp_rd_q.pop_front();
            check("rd_data", {32'h0, rd_data}, {32'h0, e_rd});
          end
        end
        if (prev_busy && !busy) begin
          if (exp_hl_q.size() == 0) begin
            check("hilo_unexpected", 64'd1, 64'd0);
          end else begin
            e_hl = exp_hl_q.pop_front();
            check("hi_lo", {hi, lo}, e_hl);
          end
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int st;
    int lat;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    IR       = 32'h0000_0000;
    rs_val   = 32'h0000_0000;
    rt_val   = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {63'h0, busy},  64'd0);
    check("rst_stall", {63'h0, stall}, 64'd0);
    check("rst_hilo",  {hi, lo},       64'd0);
    check("rst_wen",   {60'h0, rd_byte_w_en}, {60'h0, 4'b1111});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MULTU all-ones squared, with latency to busy low
    exp_hl_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    wait_idle(lat);
    check("multu_latency", lat, 64'd33);

    // MULT -3*7 followed immediately by a stalled MFLO
    exp_hl_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(MULT, 32'hFFFF_FFFD, 32'h0000_0007, st);
    exp_rd_q.push_back(32'hFFFF_FFEB);
    issue(MFLO, 32'h0, 32'h0, st);
    check("mflo_stall_cycles", st, 64'd33);

    // Signed divide with negative remainder, then unsigned divide by zero
    exp_hl_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(DIV, 32'hFFFF_FFF9, 32'h0000_0002, st);
    wait_idle(lat);
    check("div_latency", lat, 64'd33);
    exp_hl_q.push_back({32'd100, 32'hFFFF_FFFF});
    issue(DIVU, 32'd100, 32'd0, st);
    wait_idle(lat);

    // Most-negative over -1
    exp_hl_q.push_back({32'h0000_0000, 32'h8000_0000});
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    wait_idle(lat);

    // MTHI/MFHI and MTLO/MFLO back to back
    issue(MTHI, 32'h1234_5678, 32'h0, st);
    exp_rd_q.push_back(32'h1234_5678);
    issue(MFHI, 32'h0, 32'h0, st);
    check("mfhi_no_stall", st, 64'd0);
    issue(MTLO, 32'hA5A5_0001, 32'h0, st);
    exp_rd_q.push_back(32'hA5A5_0001);
    issue(MFLO, 32'h0, 32'h0, st);
    check("mflo_no_stall", st, 64'd0);

    // Non-MDU instruction while busy never stalls
    exp_hl_q.push_back({32'h0, 32'd30});
    issue(MULTU, 32'd5, 32'd6, st);
    in_valid = 1'b1;
    IR       = rtype(ADDU);
    @(negedge clk);
    check("addu_stall", {63'h0, stall}, 64'd0);
    check("addu_busy",  {63'h0, busy},  64'd1);
    check("addu_wen",   {60'h0, rd_byte_w_en}, {60'h0, 4'b1111});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    IR       = 32'h0;
    wait_idle(lat);

    // Asynchronous reset in the middle of a divide
    issue(DIV, 32'd1000, 32'd7, st);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'h0, busy}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_hl_q.push_back({32'h0, 32'd6});
    issue(MULT, 32'd2, 32'd3, st);
    wait_idle(lat);
    check("mult_after_rst_latency", lat, 64'd33);

    repeat (2) @(posedge clk);
    check("hilo_queue_drained", exp_hl_q.size(), 64'd0);
    check("rd_queue_drained",   exp_rd_q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
